ahb_lite_sram_slave: RTL and testbench
======================================

# ahb_lite_sram_slave

AHB-Lite responder holding a word-addressed register/SRAM array that produces the HRDATA, HREADYOUT and HRESP signals gathered by the slave-to-master response multiplexer. It decodes nothing itself: the system decoder drives HSEL. The block accepts pipelined address phases, inserts programmable wait states, performs byte/halfword/word writes, and returns the two-cycle AHB ERROR response for illegal accesses.

## Interface
- DEPTH, 64: number of 32-bit words; legal byte addresses are 0 to DEPTH*4-1 (HADDR low bits only).
- WAIT_STATES, 0: HREADYOUT-low cycles inserted before every OKAY data phase completes; used only when AHB_SLV_WAIT_EN is defined.
- HCLK  input  1  bus clock; all state updates on rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- HSEL  input  1  slave select from the address decoder.
- HADDR  input  32  byte address.
- HTRANS  input  2  transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- HWRITE  input  1  1 = write.
- HSIZE  input  3  0 = byte, 1 = halfword, 2 = word.
- HWDATA  input  32  write data, valid in the data phase.
- HREADY  input  1  global ready returned by the response multiplexer.
- HRDATA  output  32  read data.
- HREADYOUT  output  1  this slave's ready.
- HRESP  output  1  0 = OKAY, 1 = ERROR.

## Operation
- Address phase accepted on a rising edge where HSEL & HREADY & HTRANS[1]; registers HADDR, HWRITE, HSIZE. IDLE/BUSY or unselected cycles give a zero-wait OKAY.
- Illegal access: HADDR >= DEPTH*4, HSIZE > 2, halfword with HADDR[0]=1, word with HADDR[1:0]!=0. Illegal accesses never modify memory.
- FSM states: IDLE, WAIT, ACCESS, ERR1, ERR2.
  - IDLE/ACCESS/ERR2 with HREADY=1: accepted legal transfer -> WAIT if WAIT_STATES>0 else ACCESS; accepted illegal -> ERR1; none -> IDLE.
  - WAIT: counter loaded with WAIT_STATES-1, decrements each cycle; at 0 -> ACCESS.
  - ERR1 -> ERR2 unconditionally.
- Outputs per state: IDLE HREADYOUT=1 HRESP=0; WAIT 0/0; ACCESS 1/0; ERR1 0/1; ERR2 1/1.
- Writes commit on the edge ending ACCESS: lanes selected by HSIZE and registered HADDR[1:0], HWDATA sampled that edge.
- Reads: HRDATA = mem[registered word address] whenever state is ACCESS (full word, master picks lanes); HRDATA=0 in all other states.
- Wait counter width $clog2(WAIT_STATES+1); no wrap (load/decrement to zero only).

## Timing
- Reset (asynchronous, any state): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, counter 0. Memory array not reset. A transfer in flight is abandoned; a pending write is dropped.
- Zero-wait latency: address edge N, data/response completes at edge N+1.
- With WAIT_STATES=W: HREADYOUT low for W cycles, completes at edge N+1+W.
- Error: ERR1 one cycle, ERR2 one cycle; a new address phase presented during ERR2 (HREADY=1) is accepted.
- Back-to-back write then read same address: read data phase returns the newly written value (write commits at the edge the read address is sampled; read is combinational from the array afterwards).
- Address phases while HREADY=0 (another slave stalling) are ignored.

## Configuration
- AHB_SLV_WAIT_EN defined: WAIT state and counter present; WAIT_STATES honoured.
- Undefined: no WAIT state or counter; every legal transfer completes with zero waits regardless of WAIT_STATES.

## Structure
- Shared package ahb_pkg: HTRANS encodings, HSIZE encodings, HRESP OKAY/ERROR constants, FSM state typedef.
- One sub-module ahb_byte_lane_mask: HSIZE + HADDR[1:0] -> 4-bit write lane enable.

## Test plan
- Reset mid-WAIT (WAIT_STATES=2, write issued, HRESETn low one cycle later) -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; target word unchanged.
- Word write 0xDEADBEEF to 0x10 then read 0x10 back-to-back, zero waits -> read completes next cycle with HRDATA=0xDEADBEEF, HRESP=0.
- Byte write 0xAA to 0x13 over 0x11223344 -> read 0x10 returns 0xAA223344; halfword 0x5566 to 0x12 -> 0x55663344.
- Read HADDR=DEPTH*4 (0x100) -> HREADYOUT 0 then 1, HRESP 1 for both cycles; word write to 0x02 -> same ERROR, memory unchanged.
- With AHB_SLV_WAIT_EN, WAIT_STATES=3: read -> HREADYOUT low exactly 3 cycles, data valid on 4th; without macro -> zero waits.
- HTRANS=BUSY or HSEL=0 or HREADY=0 during address phase -> state stays IDLE, HREADYOUT=1, no memory change.

Source files
------------

// File: rtl/ahb_pkg.sv
`default_nettype none
// ahb_pkg: AHB-Lite transfer/size/response encodings and the SRAM responder FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } ahb_state_t;

  function automatic logic trans_active(input logic [1:0] htrans);
    logic active;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
      default:                   active = 1'b0;
    endcase
    return active;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_byte_lane_mask.sv
`default_nettype none
// ahb_byte_lane_mask: converts a transfer size and byte offset into the 4-bit write lane enable.
module ahb_byte_lane_mask
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] offset,
  output logic [3:0] lane_en
);

  always_comb begin
    lane_en = 4'b0000;
    case (size)
      HSIZE_BYTE: lane_en = 4'b0001 << offset;
      HSIZE_HALF: lane_en = offset[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lane_en = 4'b1111;
      default:    lane_en = 4'b0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ahb_lite_sram_slave.sv
`default_nettype none
// ahb_lite_sram_slave: AHB-Lite word-addressed SRAM responder with byte-lane writes and two-cycle ERROR.
// Wait-state insertion (WAIT state + counter) exists only when AHB_SLV_WAIT_EN is defined.
module ahb_lite_sram_slave
  import ahb_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);

  ahb_state_t    state;
  logic [AW-1:0] word_q;
  logic [1:0]    offset_q;
  logic [2:0]    size_q;
  logic          write_q;
  logic [3:0]    lane_en;
  logic          accept;
  logic          illegal;
  logic [31:0]   mem [DEPTH];

`ifdef AHB_SLV_WAIT_EN
  localparam int          CW        = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam bit          USE_WAIT  = (WAIT_STATES > 0);
  localparam logic [CW-1:0] WAIT_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;
  logic [CW-1:0] wait_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = (WAIT_STATES < 0);
`endif

  assign accept = HSEL & HREADY & trans_active(HTRANS);

  always_comb begin
    illegal = (HADDR >= BYTE_LIMIT);
    case (HSIZE)
      HSIZE_BYTE: ;
      HSIZE_HALF: if (HADDR[0]) illegal = 1'b1;
      HSIZE_WORD: if (HADDR[1:0] != 2'b00) illegal = 1'b1;
      default:    illegal = 1'b1;
    endcase
  end

  ahb_byte_lane_mask u_lane_mask (
    .size    (size_q),
    .offset  (offset_q),
    .lane_en (lane_en)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      word_q    <= '0;
      offset_q  <= '0;
      size_q    <= HSIZE_BYTE;
      write_q   <= 1'b0;
`ifdef AHB_SLV_WAIT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_ACCESS, ST_ERR2: begin
          if (accept) begin
            word_q   <= HADDR[AW+1:2];
            offset_q <= HADDR[1:0];
            size_q   <= HSIZE;
            write_q  <= HWRITE;
            if (illegal) begin
              state     <= ST_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= HRESP_ERROR;
            end
`ifdef AHB_SLV_WAIT_EN
            else if (USE_WAIT) begin
              state     <= ST_WAIT;
              HREADYOUT <= 1'b0;
              HRESP     <= HRESP_OKAY;
              wait_cnt  <= WAIT_LOAD;
            end
`endif
            else begin
              state     <= ST_ACCESS;
              HREADYOUT <= 1'b1;
              HRESP     <= HRESP_OKAY;
            end
          end else begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
          end
        end
        ST_WAIT: begin
`ifdef AHB_SLV_WAIT_EN
          if (wait_cnt == '0) begin
            state     <= ST_ACCESS;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
`else
          state     <= ST_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
`endif
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        default: begin
          state     <= ST_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // ACCESS is only ever entered for a legal transfer, so write_q/word_q are trusted here.
  always_ff @(posedge HCLK) begin
    if (state == ST_ACCESS && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[word_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA = (state == ST_ACCESS) ? mem[word_q] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_sram_slave.sv
`default_nettype none
// tb_ahb_lite_sram_slave: bus driver pushes an expected response per accepted address phase;
// a data-phase monitor pops and checks response, wait count and read data.
module tb_ahb_lite_sram_slave;
  import ahb_pkg::*;

`ifdef AHB_SLV_WAIT_EN
  localparam int EXP_WAIT = 3;
`else
  localparam int EXP_WAIT = 0;
`endif

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = 32'h0;
  logic [1:0]  HTRANS = HTRANS_IDLE;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = HSIZE_WORD;
  logic [31:0] HWDATA = 32'h0;
  logic        force_nrdy = 1'b0;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  assign HREADY = HREADYOUT & ~force_nrdy;

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_slave #(.DEPTH(64), .WAIT_STATES(3)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        sb[$];
  logic [31:0] model [64];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic exp_illegal(input logic [31:0] a, input logic [2:0] s);
    return (a >= 32'h100) || (s > 3'd2) || (s == 3'd1 && a[0]) ||
           (s == 3'd2 && a[1:0] != 2'b00);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
    int nbytes;
    int first;
    nbytes = 1 << s;
    first  = int'(a[1:0]);
    for (int k = 0; k < nbytes; k++)
      model[a[7:2]][8*(first+k) +: 8] = wd[8*(first+k) +: 8];
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!HREADY && n < 64);
    if (!HREADY) check_value(tag, {31'b0, HREADY}, 32'h1);
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input logic [1:0] trans, input logic wr, input logic [31:0] a,
                            input logic [2:0] s, input logic [31:0] wd, input bit track);
    exp_t e;
    HSEL = 1'b1; HTRANS = trans; HWRITE = wr; HADDR = a; HSIZE = s;
    wait_ready("addr_ready_timeout");
    HWDATA = wd;
    if (track) begin
      e.rd   = !wr;
      e.err  = exp_illegal(a, s);
      e.data = 32'h0;
      if (!e.err) begin
        if (wr) model_write(a, s, wd);
        else    e.data = model[a[7:2]];
      end
      sb.push_back(e);
    end
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    wait_ready("idle_ready_timeout");
  endtask

  task automatic ignored_phase(input logic sel, input logic [1:0] trans, input logic nrdy);
    HSEL = sel; HTRANS = trans; HWRITE = 1'b1; HADDR = 32'h10; HSIZE = HSIZE_WORD;
    force_nrdy = nrdy;
    @(posedge HCLK);
    #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; force_nrdy = 1'b0; HWDATA = 32'hFFFF_FFFF;
    @(negedge HCLK);
    check_value("ignored_readyout", {31'b0, HREADYOUT}, 32'h1);
    check_value("ignored_resp", {31'b0, HRESP}, 32'h0);
    @(posedge HCLK);
    #1;
  endtask

  // Data-phase monitor: decisions made at negedge describe the following rising edge.
  logic dp_valid = 1'b0;
  int   waits = 0;
  logic first_resp = 1'b0;
  exp_t cur;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      dp_valid = 1'b0;
      waits = 0;
      sb.delete();
    end else begin
      if (dp_valid) begin
        if (HREADY) begin
          if (sb.size() == 0) begin
            check_value("unexpected_dphase", 32'h1, 32'h0);
          end else begin
            cur = sb.pop_front();
            check_value("hresp", {31'b0, HRESP}, {31'b0, cur.err});
            check_value("wait_cycles", 32'(waits), cur.err ? 32'd1 : 32'(EXP_WAIT));
            if (cur.err) begin
              check_value("err_first_resp", {31'b0, first_resp}, 32'h1);
              check_value("err_hrdata", HRDATA, 32'h0);
            end else if (waits > 0) begin
              check_value("wait_resp", {31'b0, first_resp}, 32'h0);
            end
            if (cur.rd && !cur.err) check_value("hrdata", HRDATA, cur.data);
          end
          waits = 0;
        end else begin
          waits++;
          if (waits == 1) first_resp = HRESP;
        end
      end
      if (HREADY) dp_valid = HSEL & HTRANS[1];
    end
  end

  initial begin
    repeat (2) @(posedge HCLK);
    #1;
    check_value("rst_readyout", {31'b0, HREADYOUT}, 32'h1);
    check_value("rst_resp", {31'b0, HRESP}, 32'h0);
    check_value("rst_hrdata", HRDATA, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Back-to-back word write then read of the same address.
    addr_phase(HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'hDEAD_BEEF, 1'b1);
    addr_phase(HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 1'b1);
    bus_idle();

    // Sub-word writes merge into an existing word.
    addr_phase(HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'h1122_3344, 1'b1);
    addr_phase(HTRANS_NONSEQ, 1'b1, 32'h13, HSIZE_BYTE, 32'hAA00_0000, 1'b1);
    addr_phase(HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 1'b1);
    addr_phase(HTRANS_NONSEQ, 1'b1, 32'h12, HSIZE_HALF, 32'h5566_0000, 1'b1);
    addr_phase(HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 1'b1);
    addr_phase(HTRANS_NONSEQ, 1'b1, 32'h05, HSIZE_BYTE, 32'h0000_7700, 1'b1);
    bus_idle();

    // Illegal accesses, including one accepted during ERR2.
    addr_phase(HTRANS_NONSEQ, 1'b1, 32'h00, HSIZE_WORD, 32'hCAFE_F00D, 1'b1);
    addr_phase(HTRANS_NONSEQ, 1'b0, 32'h100, HSIZE_WORD, 32'h0, 1'b1);
    addr_phase(HTRANS_NONSEQ, 1'b1, 32'h02, HSIZE_WORD, 32'h0BAD_BAD0, 1'b1);
    addr_phase(HTRANS_NONSEQ, 1'b1, 32'h01, HSIZE_HALF, 32'h1234_5678, 1'b1);
    addr_phase(HTRANS_NONSEQ, 1'b0, 32'h04, 3'd3, 32'h0, 1'b1);
    addr_phase(HTRANS_NONSEQ, 1'b0, 32'h00, HSIZE_WORD, 32'h0, 1'b1);
    bus_idle();

    // Short incrementing burst.
    addr_phase(HTRANS_NONSEQ, 1'b1, 32'h14, HSIZE_WORD, 32'hA5A5_0001, 1'b1);
    addr_phase(HTRANS_SEQ,    1'b1, 32'h18, HSIZE_WORD, 32'h5A5A_0002, 1'b1);
    addr_phase(HTRANS_SEQ,    1'b1, 32'h1C, HSIZE_WORD, 32'h0F0F_0003, 1'b1);
    addr_phase(HTRANS_NONSEQ, 1'b0, 32'h18, HSIZE_WORD, 32'h0, 1'b1);
    addr_phase(HTRANS_SEQ,    1'b0, 32'h1C, HSIZE_WORD, 32'h0, 1'b1);
    addr_phase(HTRANS_NONSEQ, 1'b0, 32'h14, HSIZE_WORD, 32'h0, 1'b1);
    bus_idle();

    // Address phases that must be ignored.
    ignored_phase(1'b1, HTRANS_BUSY,   1'b0);
    ignored_phase(1'b0, HTRANS_NONSEQ, 1'b0);
    ignored_phase(1'b1, HTRANS_NONSEQ, 1'b1);
    addr_phase(HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 1'b1);
    bus_idle();

    // Reset while a write is in flight drops it.
    addr_phase(HTRANS_NONSEQ, 1'b1, 32'h20, HSIZE_WORD, 32'h1234_5678, 1'b1);
    bus_idle();
    addr_phase(HTRANS_NONSEQ, 1'b1, 32'h20, HSIZE_WORD, 32'hFFFF_FFFF, 1'b0);
    #2;
    HRESETn = 1'b0;
    #1;
    check_value("midrst_readyout", {31'b0, HREADYOUT}, 32'h1);
    check_value("midrst_resp", {31'b0, HRESP}, 32'h0);
    check_value("midrst_hrdata", HRDATA, 32'h0);
    HSEL = 1'b0;
    HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    addr_phase(HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_WORD, 32'h0, 1'b1);
    bus_idle();

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge HCLK);
    check_value("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
